// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller
// Debugger-facing run/step/halt controller for a simple in-order pipeline.
// Moore FSM: stall, prog_reset, cmd_ready and state decode from the state
// register; o_done is a registered one-cycle pulse.
// Optional feature: define PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN to add a
// PC breakpoint comparator (i_bp_addr / i_bp_valid ports).
// DRAIN_CYCLES must be >= 1.
module pipeline_run_controller #(
  parameter int SIZE         = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cmd_valid,
  input  logic [1:0]      i_cmd,
  output logic            o_cmd_ready,
  input  logic [SIZE-1:0] i_pc,
  input  logic            i_halt_fetched,
`ifdef PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN
  input  logic [SIZE-1:0] i_bp_addr,
  input  logic            i_bp_valid,
`endif
  output logic            o_stall,
  output logic            o_prog_reset,
  output logic            o_done,
  output logic [2:0]      o_state,
  output logic [SIZE-1:0] o_cycle_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_PRESET = 3'd5;

  localparam logic [1:0] CMD_RUN    = 2'b00;
  localparam logic [1:0] CMD_STEP   = 2'b01;
  localparam logic [1:0] CMD_HALT   = 2'b10;
  localparam logic [1:0] CMD_PRESET = 2'b11;

  // Drain counter counts DRAIN_CYCLES-1 down to 0, giving DRAIN_CYCLES cycles.
  localparam int             DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic            w_done_set;
  logic [DCW-1:0]  r_drain_cnt;
  logic            r_done;
  logic [SIZE-1:0] r_cycle_count;
  logic            w_cmd_acc;
  logic            w_bp_hit;

  // Moore decodes from the state register only.
  assign o_cmd_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_DONE);
  assign o_stall      = !((r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN));
  assign o_prog_reset = (r_state == ST_PRESET);
  assign o_state      = r_state;
  assign o_done       = r_done;
  assign o_cycle_count = r_cycle_count;

  assign w_cmd_acc = i_cmd_valid && o_cmd_ready;

`ifdef PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN
  logic r_bp_mask;

  // Mask the match in the first RUN cycle so a run can resume from the breakpoint PC.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bp_mask <= 1'b0;
    end else begin
      r_bp_mask <= (r_state == ST_IDLE) && (w_next_state == ST_RUN);
    end
  end

  assign w_bp_hit = i_bp_valid && (i_pc == i_bp_addr) && !r_bp_mask;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^i_pc;
  assign w_bp_hit    = 1'b0;
`endif

  // Next-state and done-pulse request.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    w_next_state = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          if (i_cmd == CMD_RUN)         w_next_state = ST_RUN;
          else if (i_cmd == CMD_STEP)   w_next_state = ST_STEP;
          else if (i_cmd == CMD_PRESET) w_next_state = ST_PRESET;
        end
      end
      ST_RUN: begin
        // Precedence: PROG_RESET > HALT fetched > breakpoint > HALT command.
        if (w_cmd_acc && (i_cmd == CMD_PRESET)) begin
          w_next_state = ST_PRESET;
        end else if (i_halt_fetched) begin
          w_next_state = ST_DRAIN;
        end else if (w_bp_hit || (w_cmd_acc && (i_cmd == CMD_HALT))) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      ST_STEP: begin
        if (i_halt_fetched) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_next_state = ST_DONE;
          w_done_set   = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_cmd_acc && (i_cmd == CMD_PRESET)) w_next_state = ST_PRESET;
      end
      ST_PRESET: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so all registers update together.
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_set;
    end
  end

  // Drain counter: load on DRAIN entry, count down while draining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drain_cnt <= '0;
    end else if ((w_next_state == ST_DRAIN) && (r_state != ST_DRAIN)) begin
      r_drain_cnt <= DRAIN_LOAD;
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - DCW'(1);
    end
  end

  // Saturating count of unstalled cycles; cleared on entry to PRESET.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_count <= '0;
    end else if (w_next_state == ST_PRESET) begin
      r_cycle_count <= '0;
    end else if (!o_stall && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + SIZE'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench for pipeline_run_controller.
// Main instance uses defaults (SIZE=32, DRAIN_CYCLES=4); a second instance
// (SIZE=3, DRAIN_CYCLES=1) covers counter saturation and the shortest drain.
// Breakpoint scenario is compiled when PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN is defined.
module tb_pipeline_run_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                         S_DRAIN = 3'd3, S_DONE = 3'd4, S_PRESET = 3'd5;
  localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_HALT = 2'b10, C_PRESET = 2'b11;

  typedef struct {
    logic [2:0]  state;
    logic [31:0] count;
    int          wait_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [31:0] pc = '0;
  logic        halt_fetched = 1'b0;
  logic [31:0] bp_addr = '0;
  logic        bp_valid = 1'b0;
  logic        cmd_ready, stall, prog_reset, done;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  logic        d1_cmd_valid = 1'b0;
  logic [1:0]  d1_cmd = 2'b00;
  logic        d1_halt = 1'b0;
  logic        d1_ready, d1_stall, d1_prog_reset, d1_done;
  logic [2:0]  d1_state;
  logic [2:0]  d1_count;

  always #5 clk = ~clk;

  pipeline_run_controller u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(cmd_ready), .i_pc(pc), .i_halt_fetched(halt_fetched),
`ifdef PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN
    .i_bp_addr(bp_addr), .i_bp_valid(bp_valid),
`endif
    .o_stall(stall), .o_prog_reset(prog_reset), .o_done(done),
    .o_state(state), .o_cycle_count(cycle_count)
  );

  pipeline_run_controller #(.SIZE(3), .DRAIN_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(d1_cmd_valid), .i_cmd(d1_cmd),
    .o_cmd_ready(d1_ready), .i_pc(3'd0), .i_halt_fetched(d1_halt),
`ifdef PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN
    .i_bp_addr(3'd0), .i_bp_valid(1'b0),
`endif
    .o_stall(d1_stall), .o_prog_reset(d1_prog_reset), .o_done(d1_done),
    .o_state(d1_state), .o_cycle_count(d1_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic d1_send(input logic [1:0] c);
    d1_cmd_valid = 1'b1;
    d1_cmd       = c;
    tick();
    d1_cmd_valid = 1'b0;
  endtask

  // Scoreboard consumer: waits for o_done, pops the expected entry and compares.
  task automatic wait_done(input string name, input int max_cyc);
    exp_t e;
    int   n;
    n = 0;
    while (o_done_now() !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_queue: o_done seen with empty scoreboard, expected an entry", name);
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: o_done=%b after %0d cycles, expected 1", name, done, max_cyc);
      return;
    end
    n_checks++;
    if (n != e.wait_cyc) begin
      n_fail++; $display("FAIL %s_latency: got %0d cycles, expected %0d", name, n, e.wait_cyc);
    end
    n_checks++;
    if (state !== e.state) begin
      n_fail++; $display("FAIL %s_state: got %0d, expected %0d", name, state, e.state);
    end
    n_checks++;
    if (cycle_count !== e.count) begin
      n_fail++; $display("FAIL %s_count: got %0d, expected %0d", name, cycle_count, e.count);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL %s_pulse_width: o_done=%b one cycle later, expected 0", name, done);
    end
  endtask

  function automatic logic o_done_now();
    return done;
  endfunction

  task automatic test_reset();
    #2;
    n_checks++;
    if ({state, stall, prog_reset, done, cmd_ready} !== {S_IDLE, 4'b1001}) begin
      n_fail++; $display("FAIL reset_outputs: got st=%0d stall=%b pr=%b done=%b rdy=%b, expected st=0 1 0 0 1",
                         state, stall, prog_reset, done, cmd_ready);
    end
    tick();
    n_checks++;
    if (cycle_count !== 32'd0 || d1_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d/%0d, expected 0/0", cycle_count, d1_count);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (state !== S_IDLE || stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: got st=%0d stall=%b, expected st=0 stall=1", state, stall);
    end
  endtask

  task automatic test_run_drain();
    send_cmd(C_RUN);
    repeat (9) tick();
    n_checks++;
    if (state !== S_RUN || cycle_count !== 32'd9 || stall !== 1'b0) begin
      n_fail++; $display("FAIL run_progress: got st=%0d cnt=%0d stall=%b, expected st=1 cnt=9 stall=0",
                         state, cycle_count, stall);
    end
    halt_fetched = 1'b1;
    exp_q.push_back('{S_DONE, 32'd14, 4});
    tick();
    halt_fetched = 1'b0;
    n_checks++;
    if (state !== S_DRAIN || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL drain_entry: got st=%0d rdy=%b, expected st=3 rdy=0", state, cmd_ready);
    end
    wait_done("run_drain", 20);
  endtask

  task automatic test_done_ignore_preset();
    send_cmd(C_RUN);
    n_checks++;
    if (state !== S_DONE || done !== 1'b0 || stall !== 1'b1 || cycle_count !== 32'd14) begin
      n_fail++; $display("FAIL done_ignore_run: got st=%0d done=%b stall=%b cnt=%0d, expected st=4 0 1 14",
                         state, done, stall, cycle_count);
    end
    send_cmd(C_PRESET);
    n_checks++;
    if (state !== S_PRESET || prog_reset !== 1'b1 || cycle_count !== 32'd0 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL preset_pulse: got st=%0d pr=%b cnt=%0d rdy=%b, expected st=5 1 0 0",
                         state, prog_reset, cycle_count, cmd_ready);
    end
    tick();
    n_checks++;
    if (state !== S_IDLE || prog_reset !== 1'b0 || cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL preset_exit: got st=%0d pr=%b cnt=%0d, expected st=0 0 0",
                         state, prog_reset, cycle_count);
    end
  endtask

  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      send_cmd(C_STEP);
      n_checks++;
      if (state !== S_STEP || stall !== 1'b0 || cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL step_%0d_window: got st=%0d stall=%b rdy=%b, expected st=2 0 0",
                           i, state, stall, cmd_ready);
      end
      exp_q.push_back('{S_IDLE, 32'(i + 1), 1});
      wait_done("step", 4);
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++; $display("FAIL step_%0d_stall_after: got %b, expected 1", i, stall);
      end
    end
  endtask

  task automatic test_halt_priority();
    send_cmd(C_RUN);
    tick();
    halt_fetched = 1'b1;
    send_cmd(C_HALT);
    halt_fetched = 1'b0;
    n_checks++;
    if (state !== S_DRAIN || done !== 1'b0) begin
      n_fail++; $display("FAIL halt_vs_fetch: got st=%0d done=%b, expected st=3 done=0", state, done);
    end
    exp_q.push_back('{S_DONE, 32'd9, 3});
    send_cmd(C_PRESET);
    n_checks++;
    if (state !== S_DRAIN || prog_reset !== 1'b0) begin
      n_fail++; $display("FAIL drain_cmd_blocked: got st=%0d pr=%b, expected st=3 pr=0", state, prog_reset);
    end
    wait_done("halt_priority", 10);
  endtask

  task automatic test_run_halt_cmd();
    send_cmd(C_PRESET);
    tick();
    send_cmd(C_RUN);
    send_cmd(C_STEP);
    n_checks++;
    if (state !== S_RUN || cycle_count !== 32'd1) begin
      n_fail++; $display("FAIL run_ignore_step: got st=%0d cnt=%0d, expected st=1 cnt=1", state, cycle_count);
    end
    tick();
    exp_q.push_back('{S_IDLE, 32'd3, 0});
    send_cmd(C_HALT);
    wait_done("run_halt", 2);
  endtask

  task automatic test_preset_priority();
    send_cmd(C_HALT);
    n_checks++;
    if (state !== S_IDLE || done !== 1'b0 || cycle_count !== 32'd3) begin
      n_fail++; $display("FAIL idle_halt_ignored: got st=%0d done=%b cnt=%0d, expected st=0 0 3",
                         state, done, cycle_count);
    end
    send_cmd(C_RUN);
    halt_fetched = 1'b1;
    send_cmd(C_PRESET);
    halt_fetched = 1'b0;
    n_checks++;
    if (state !== S_PRESET || prog_reset !== 1'b1 || cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL preset_over_fetch: got st=%0d pr=%b cnt=%0d, expected st=5 1 0",
                         state, prog_reset, cycle_count);
    end
    tick();
    n_checks++;
    if (state !== S_IDLE || prog_reset !== 1'b0) begin
      n_fail++; $display("FAIL preset_one_cycle: got st=%0d pr=%b, expected st=0 pr=0", state, prog_reset);
    end
  endtask

`ifdef PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN
  task automatic test_breakpoint();
    bp_addr  = 32'h10;
    bp_valid = 1'b1;
    pc       = 32'h08;
    send_cmd(C_RUN);
    pc = 32'h0C;
    tick();
    pc = 32'h10;
    exp_q.push_back('{S_IDLE, 32'd2, 0});
    tick();
    wait_done("bp_hit", 2);
    send_cmd(C_RUN);
    tick();
    n_checks++;
    if (state !== S_RUN || done !== 1'b0) begin
      n_fail++; $display("FAIL bp_resume: got st=%0d done=%b, expected st=1 done=0", state, done);
    end
    pc = 32'h14;
    tick();
    exp_q.push_back('{S_IDLE, 32'd5, 0});
    send_cmd(C_HALT);
    wait_done("bp_resume_halt", 2);
    bp_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_in_drain();
    send_cmd(C_RUN);
    halt_fetched = 1'b1;
    tick();
    halt_fetched = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== S_IDLE || stall !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_drain: got st=%0d stall=%b done=%b cnt=%0d, expected st=0 1 0 0",
                         state, stall, done, cycle_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || state !== S_IDLE) begin
        n_fail++; $display("FAIL reset_hold_%0d: got st=%0d done=%b, expected st=0 done=0", i, state, done);
      end
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (state !== S_IDLE || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_recover: got st=%0d done=%b rdy=%b, expected st=0 0 1", state, done, cmd_ready);
    end
  endtask

  task automatic test_saturate_drain_one();
    d1_send(C_RUN);
    repeat (9) tick();
    n_checks++;
    if (d1_count !== 3'd7 || d1_state !== S_RUN) begin
      n_fail++; $display("FAIL saturate: got cnt=%0d st=%0d, expected cnt=7 st=1", d1_count, d1_state);
    end
    d1_halt = 1'b1;
    tick();
    d1_halt = 1'b0;
    n_checks++;
    if (d1_state !== S_DRAIN || d1_done !== 1'b0) begin
      n_fail++; $display("FAIL drain1_entry: got st=%0d done=%b, expected st=3 done=0", d1_state, d1_done);
    end
    tick();
    n_checks++;
    if (d1_state !== S_DONE || d1_done !== 1'b1 || d1_count !== 3'd7) begin
      n_fail++; $display("FAIL drain1_exit: got st=%0d done=%b cnt=%0d, expected st=4 1 7",
                         d1_state, d1_done, d1_count);
    end
    tick();
    n_checks++;
    if (d1_done !== 1'b0) begin
      n_fail++; $display("FAIL drain1_pulse: got done=%b, expected 0", d1_done);
    end
  endtask

  initial begin
    test_reset();
    test_run_drain();
    test_done_ignore_preset();
    test_step();
    test_halt_priority();
    test_run_halt_cmd();
    test_preset_priority();
`ifdef PIPELINE_RUN_CONTROLLER_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_reset_in_drain();
    test_saturate_drain_one();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drained: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
